// File: rtl/dm_arbiter_if.sv
// Requester ports and memory bus of the two-port data-memory arbiter.
interface dm_arbiter_if #(
  parameter int unsigned IDX_W = 12
);
  logic             p0_req;
  logic             p0_we;
  logic [1:0]       p0_size;
  logic             p0_sgn;
  logic [31:0]      p0_addr;
  logic [31:0]      p0_wdata;
  logic             p0_ack;
  logic             p0_err;
  logic [31:0]      p0_rdata;

  logic             p1_req;
  logic             p1_we;
  logic [1:0]       p1_size;
  logic             p1_sgn;
  logic [31:0]      p1_addr;
  logic [31:0]      p1_wdata;
  logic             p1_ack;
  logic             p1_err;
  logic [31:0]      p1_rdata;

  logic [IDX_W-1:0] mem_addr;
  logic             mem_we;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  // Arbiter side
  modport slave (
    input  p0_req, p0_we, p0_size, p0_sgn, p0_addr, p0_wdata,
    output p0_ack, p0_err, p0_rdata,
    input  p1_req, p1_we, p1_size, p1_sgn, p1_addr, p1_wdata,
    output p1_ack, p1_err, p1_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  // Requester and memory side
  modport master (
    output p0_req, p0_we, p0_size, p0_sgn, p0_addr, p0_wdata,
    input  p0_ack, p0_err, p0_rdata,
    output p1_req, p1_we, p1_size, p1_sgn, p1_addr, p1_wdata,
    input  p1_ack, p1_err, p1_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin two-port arbiter and access sequencer for a word-organised data memory.
// Sub-word stores are turned into a read-modify-write so memory only sees word writes.
module dm_arbiter #(
  parameter int unsigned IDX_W = 12
) (
  input  logic         clk,
  input  logic         reset,
  dm_arbiter_if.slave  bus
);

  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {IDLE, EXEC, MERGE, DONE} state_e;

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               port_q, port_d;
  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic               sgn_q, sgn_d;
  logic [DW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [DW-1:0]      old_word_q, old_word_d;
  logic [1:0]         ack_q, ack_d;
  logic [1:0]         err_q, err_d;
  logic [1:0][DW-1:0] rdata_q, rdata_d;

  logic [1:0]         req;
  logic               sel;
  logic               in_we;
  logic [1:0]         in_size;
  logic               in_sgn;
  logic [DW-1:0]      in_addr;
  logic [DW-1:0]      in_wdata;
  logic               in_bad;

  logic [4:0]         shamt;
  logic [DW-1:0]      shifted;
  logic [DW-1:0]      load_val;
  logic [DW-1:0]      lane_mask;
  logic [DW-1:0]      merged;
  logic               word_store;

  // Winner selection: alternate on a tie, lone requester always wins
  assign req      = {bus.p1_req, bus.p0_req};
  assign sel      = (req == 2'b11) ? ~last_grant_q : req[1];
  assign in_we    = sel ? bus.p1_we    : bus.p0_we;
  assign in_size  = sel ? bus.p1_size  : bus.p0_size;
  assign in_sgn   = sel ? bus.p1_sgn   : bus.p0_sgn;
  assign in_addr  = sel ? bus.p1_addr  : bus.p0_addr;
  assign in_wdata = sel ? bus.p1_wdata : bus.p0_wdata;

  // Illegal size, misalignment, or address beyond the memory
  assign in_bad = (in_size == 2'b11) ||
                  ((in_size == 2'b00) && (in_addr[1:0] != 2'b00)) ||
                  ((in_size == 2'b10) && in_addr[0]) ||
                  ((in_addr >> (IDX_W + 2)) != DW'(0));

  // Lane extraction for loads and lane replacement for sub-word stores
  assign shamt     = {addr_q[1:0], 3'b000};
  assign shifted   = bus.mem_rdata >> shamt;
  assign lane_mask = ((size_q == 2'b01) ? DW'(32'h0000_00ff) : DW'(32'h0000_ffff)) << shamt;
  assign merged    = (old_word_q & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
  assign word_store = we_q && (size_q == 2'b00);

  always_comb begin
    load_val = bus.mem_rdata;
    if (size_q == 2'b01)
      load_val = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
    else if (size_q == 2'b10)
      load_val = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
  end

  // Memory drive is a function of state; write enable is forced off during reset
  assign bus.mem_addr  = ((state_q == EXEC) || (state_q == MERGE)) ? addr_q[IDX_W+1:2] : '0;
  assign bus.mem_we    = reset && (((state_q == EXEC) && word_store) || (state_q == MERGE));
  assign bus.mem_wdata = (state_q == MERGE) ? merged :
                         ((state_q == EXEC) && word_store) ? wdata_q : '0;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    old_word_d   = old_word_q;
    ack_d        = '0;
    err_d        = '0;
    rdata_d      = '0;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          port_d  = sel;
          we_d    = in_we;
          size_d  = in_size;
          sgn_d   = in_sgn;
          addr_d  = in_addr;
          wdata_d = in_wdata;
          if (in_bad) begin
            ack_d[sel] = 1'b1;
            err_d[sel] = 1'b1;
            state_d    = DONE;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (!we_q) begin
          ack_d[port_q]   = 1'b1;
          rdata_d[port_q] = load_val;
          state_d         = DONE;
        end else if (size_q == 2'b00) begin
          ack_d[port_q] = 1'b1;
          state_d       = DONE;
        end else begin
          old_word_d = bus.mem_rdata;
          state_d    = MERGE;
        end
      end
      MERGE: begin
        ack_d[port_q] = 1'b1;
        state_d       = DONE;
      end
      DONE: begin
        last_grant_d = port_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      sgn_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      old_word_q   <= '0;
      ack_q        <= '0;
      err_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      old_word_q   <= old_word_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign bus.p0_ack   = ack_q[0];
  assign bus.p1_ack   = ack_q[1];
  assign bus.p0_err   = err_q[0];
  assign bus.p1_err   = err_q[1];
  assign bus.p0_rdata = rdata_q[0];
  assign bus.p1_rdata = rdata_q[1];

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and access sequencer in front of the single-port, word-organised data memory (4096 x 32, synchronous write, combinational read). It accepts load/store requests from the CPU MEM stage (port 0) and the debug/DMA loader (port 1). It grants one request at a time using round-robin, and checks alignment and range. Sub-word stores become a two-cycle read-modify-write, so the memory itself only ever sees whole-word writes.

## Interface
- IDX_W, default 12, memory word-index width (4096 words); the byte address space is 2^(IDX_W+2).
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- pN_req  in  1  request from port N (N = 0, 1); held stable until pN_ack.
- pN_we  in  1  1 = store, 0 = load.
- pN_size  in  2  00 = word, 01 = byte, 10 = half; 11 is illegal.
- pN_sgn  in  1  sign-extend sub-word loads when 1, zero-extend when 0.
- pN_addr  in  32  byte address.
- pN_wdata  in  32  store data; the sub-word is taken from the low bits.
- pN_ack  out  1  one-cycle completion pulse.
- pN_err  out  1  valid with pN_ack; 1 = rejected, with no memory write.
- pN_rdata  out  32  load result, valid with pN_ack.
- mem_addr  out  IDX_W  word index to memory.
- mem_we  out  1  word write enable.
- mem_wdata  out  32  word write data.
- mem_rdata  in  32  combinational read of mem_addr.

## Operation
- States: IDLE, EXEC, MERGE, DONE.
- IDLE
  - Sample the requests, pick a winner, and latch its we/size/sgn/addr/wdata plus the port id. Then go to EXEC.
  - With no requests, stay in IDLE.
- Arbitration: round-robin. The last_grant register resets to 1, so port 0 wins the first tie. A lone requester always wins.
- Error check, at latch time. A request is an error if any of these hold:
  - size = 11;
  - word with addr[1:0] != 0;
  - half with addr[0] = 1;
  - addr[31:IDX_W+2] != 0.
- An error request goes IDLE -> DONE directly, with err = 1, rdata = 0, and no memory access.
- EXEC: mem_addr = addr[IDX_W+1:2].
  - Load: capture the extracted mem_rdata; go to DONE.
  - Word store: mem_we = 1, mem_wdata = wdata; go to DONE.
  - Sub-word store: latch mem_rdata as old_word; go to MERGE.
- MERGE: mem_we = 1, mem_wdata = old_word with the target lane replaced; go to DONE.
  - Byte: lane addr[1:0] is replaced by wdata[7:0].
  - Half: lane addr[1] is replaced by wdata[15:0].
- DONE: pulse ack for the latched port, with rdata/err valid. Update last_grant to that port. Go to IDLE.
- Load extraction: the byte/half is selected by addr[1:0], then sign- or zero-extended per sgn. Word loads pass through unchanged.
- mem_we is combinational from the state and is ANDed with reset; it is 0 while reset is low.
- rdata/ack/err are registered. The non-granted port's outputs stay 0.

## Timing
- Reset (reset = 0 at a rising edge):
  - state = IDLE; last_grant = 1.
  - All pN_ack, pN_err, pN_rdata = 0.
  - mem_addr = 0, mem_we = 0, mem_wdata = 0.
  - A transaction in flight is dropped without an ack. Any MERGE write not yet taken is not performed.
- Load or word store: request sampled at edge E0 -> EXEC in cycle 1 (write commits at E1) -> ack in cycle 2. That is 3 cycles from the sampling edge to IDLE.
- Sub-word store: EXEC, then MERGE (write at E2), then ack in cycle 3.
- Error: ack + err in cycle 1.
- Back-to-back: a requester still asserting req during its ack cycle is seen as a new request at the next IDLE sample. Requests are never sampled in EXEC/MERGE/DONE.
- Simultaneous requests: both ports requesting continuously alternate grants, 0, 1, 0, ...
- The memory sees at most one write per cycle, and never during EXEC of a sub-word store.

## Test plan
- Reset, then p0 word store addr 0x10, data 0xDEADBEEF; then p0 word load addr 0x10.
  - Store: mem_we pulses once with mem_addr = 4, and p0_ack comes 2 cycles after the sample.
  - Load: p0_rdata = 0xDEADBEEF, err = 0.
- Byte store 0xAB to addr 0x11 over the word 0xDEADBEEF.
  - Exactly one write, in MERGE, of 0xDEADABEF; ack in cycle 3.
  - A byte load of 0x11 with sgn = 1 then returns 0xFFFFFFAB; with sgn = 0 it returns 0x000000AB.
- p0 and p1 both hold req with word loads for 4 transactions: grants go p0, p1, p0, p1; each ack is a single cycle and only on the granted port.
- Misaligned and out-of-range requests: half at 0x3, word at 0x2, size 11, addr 0x4000 (IDX_W = 12).
  - Each gives ack + err = 1 in cycle 1, with mem_we never asserted.
- Reset driven low during MERGE of a byte store: no memory write and no ack. After reset, the target word is unchanged and p0 wins the first tie.
